// File: rtl/prod_accum_pkg.sv
// Shared constants for the product accumulator: default frame length,
// accumulator width, multiplier product width and beat-count width helper.
package accum_pkg;

   localparam int LEN_DEF   = 16;
   localparam int ACC_W_DEF = 40;
   localparam int PROD_W    = 32;

   // Count must reach LEN itself, hence LEN+1 codes.
   function automatic int cnt_w_f(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// Unsigned ACC_W + 32-bit adder that clamps to all-ones on carry-out and
// reports the clamp as an overflow flag.
module sat_add
   import accum_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] full;

   assign full = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
   assign ovf  = full[ACC_W];
   assign sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/prod_accum.sv
// Frames a valid/ready stream of multiplier products into saturated sums of
// up to LEN beats; one result register slot, released by out_rdy.
module prod_accum
   import accum_pkg::*;
#(
   parameter int LEN   = LEN_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = cnt_w_f(LEN)
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_ovf
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic             out_vld_q, out_vld_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] sum;
   logic             beat_ovf;
   logic             accept;
   logic             frame_end;

   assign in_rdy = !out_vld_q || out_rdy;
   assign accept = in_vld && in_rdy;

   // cnt==0 marks a fresh frame, so acc never needs clearing at frame end.
   assign base      = (cnt_q == '0) ? '0 : acc_q;
   assign frame_end = in_last || (cnt_q == CNT_W'(LEN - 1));

   sat_add #(
      .ACC_W (ACC_W)
   ) u_sat_add (
      .a   (base),
      .b   (in_prod),
      .sum (sum),
      .ovf (beat_ovf)
   );

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      out_vld_d = out_vld_q;
      out_sum_d = out_sum_q;
      out_cnt_d = out_cnt_q;
      out_ovf_d = out_ovf_q;

      if (out_vld_q && out_rdy) begin
         out_vld_d = 1'b0;
      end

      if (accept) begin
         if (frame_end) begin
            out_sum_d = sum;
            out_cnt_d = cnt_q + 1'b1;
            out_ovf_d = ovf_acc_q | beat_ovf;
            out_vld_d = 1'b1;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
         end else begin
            acc_d     = sum;
            cnt_d     = cnt_q + 1'b1;
            ovf_acc_d = ovf_acc_q | beat_ovf;
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         out_vld_q <= 1'b0;
         out_sum_q <= '0;
         out_cnt_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         out_vld_q <= out_vld_d;
         out_sum_q <= out_sum_d;
         out_cnt_q <= out_cnt_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out_vld = out_vld_q;
   assign out_sum = out_sum_q;
   assign out_cnt = out_cnt_q;
   assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: a 40-bit and a 32-bit instance share one stimulus
// stream; a per-instance model queues expected frame results.
module tb_prod_accum;

   localparam int LEN = 16;

   logic        clk;
   logic        rst;
   logic        in_vld;
   logic [31:0] in_prod;
   logic        in_last;
   logic        out_rdy;

   logic        in_rdy0, out_vld0, out_ovf0;
   logic [39:0] out_sum0;
   logic [4:0]  out_cnt0;
   logic        in_rdy1, out_vld1, out_ovf1;
   logic [31:0] out_sum1;
   logic [4:0]  out_cnt1;

   prod_accum u_dut (
      .sclk    (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy0),
      .in_prod (in_prod),
      .in_last (in_last),
      .out_vld (out_vld0),
      .out_rdy (out_rdy),
      .out_sum (out_sum0),
      .out_cnt (out_cnt0),
      .out_ovf (out_ovf0)
   );

   prod_accum #(
      .ACC_W (32)
   ) u_sat (
      .sclk    (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy1),
      .in_prod (in_prod),
      .in_last (in_last),
      .out_vld (out_vld1),
      .out_rdy (out_rdy),
      .out_sum (out_sum1),
      .out_cnt (out_cnt1),
      .out_ovf (out_ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] sum;
      int          cnt;
      bit          ovf;
   } res_t;

   res_t        q0[$];
   res_t        q1[$];
   logic [63:0] m_acc[2];
   int          m_cnt[2];
   bit          m_ovf[2];
   bit          m_pend[2];
   logic [63:0] last_sum[2];
   int          last_cnt[2];
   bit          last_ovf[2];
   int          n_frames[2];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          soak_done;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic dut_out(input int i, output logic [63:0] s, output int c, output bit o);
      s = (i == 0) ? 64'(out_sum0) : 64'(out_sum1);
      c = (i == 0) ? int'(out_cnt0) : int'(out_cnt1);
      o = (i == 0) ? out_ovf0 : out_ovf1;
   endtask

   // Reference model: one step per rising edge, using pre-edge values.
   task automatic model_step(input int i);
      logic [63:0] mx, base, s, d_sum;
      int          d_cnt;
      bit          o, d_ovf, rdy, cons, fin;
      res_t        r;
      mx = (i == 0) ? 64'hFF_FFFF_FFFF : 64'hFFFF_FFFF;
      if (rst) begin
         m_acc[i] = '0; m_cnt[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
         if (i == 0) q0.delete(); else q1.delete();
         return;
      end
      rdy  = !m_pend[i] || out_rdy;
      cons = m_pend[i] && out_rdy;
      fin  = 0;
      if (cons) begin
         dut_out(i, d_sum, d_cnt, d_ovf);
         if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            check_val($sformatf("pop_empty%0d", i), 1, 0);
         end else begin
            r = (i == 0) ? q0.pop_front() : q1.pop_front();
            check_val($sformatf("res_sum%0d", i), d_sum, r.sum);
            check_val($sformatf("res_cnt%0d", i), 64'(d_cnt), 64'(r.cnt));
            check_val($sformatf("res_ovf%0d", i), 64'(d_ovf), 64'(r.ovf));
         end
         last_sum[i] = d_sum; last_cnt[i] = d_cnt; last_ovf[i] = d_ovf;
         n_frames[i]++;
      end
      if (in_vld && rdy) begin
         base = (m_cnt[i] == 0) ? 64'd0 : m_acc[i];
         s    = base + 64'(in_prod);
         o    = s > mx;
         if (o) s = mx;
         if (in_last || m_cnt[i] == LEN - 1) begin
            r.sum = s; r.cnt = m_cnt[i] + 1; r.ovf = m_ovf[i] | o;
            if (i == 0) q0.push_back(r); else q1.push_back(r);
            m_cnt[i] = 0; m_ovf[i] = 0; fin = 1;
         end else begin
            m_acc[i] = s; m_cnt[i]++; m_ovf[i] = m_ovf[i] | o;
         end
      end
      if (fin) m_pend[i] = 1;
      else if (cons) m_pend[i] = 0;
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   // Handshake and held-result checks mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check_val("in_rdy0", 64'(in_rdy0), 64'(!m_pend[0] || out_rdy));
         check_val("in_rdy1", 64'(in_rdy1), 64'(!m_pend[1] || out_rdy));
         check_val("out_vld0", 64'(out_vld0), 64'(m_pend[0]));
         check_val("out_vld1", 64'(out_vld1), 64'(m_pend[1]));
         if (m_pend[0] && q0.size() > 0) check_val("hold_sum0", 64'(out_sum0), q0[0].sum);
         if (m_pend[1] && q1.size() > 0) check_val("hold_sum1", 64'(out_sum1), q1[0].sum);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] p, input bit last);
      bit ok;
      int t;
      t = 0;
      in_vld = 1'b1; in_prod = p; in_last = last;
      forever begin
         @(negedge clk);
         ok = !m_pend[0] || out_rdy;
         @(posedge clk);
         #1;
         if (ok) break;
         t++;
         if (t > 500) begin
            check_val("send_timeout", 1, 0);
            break;
         end
      end
      in_vld = 1'b0; in_last = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check_val({tag, "_vld"}, 64'(out_vld0), 0);
      check_val({tag, "_sum"}, 64'(out_sum0), 0);
      check_val({tag, "_cnt"}, 64'(out_cnt0), 0);
      check_val({tag, "_ovf"}, 64'(out_ovf0), 0);
      check_val({tag, "_sum1"}, 64'(out_sum1), 0);
      check_val({tag, "_rdy"}, 64'(in_rdy0), 1);
   endtask

   initial begin
      int f0;
      logic [31:0] r;
      rst = 1'b1; in_vld = 1'b0; in_prod = '0; in_last = 1'b0; out_rdy = 1'b1;
      soak_done = 0;
      for (int i = 0; i < 2; i++) n_frames[i] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset");
      @(posedge clk); #1;

      // Full 16-beat frame
      for (int k = 0; k < LEN; k++) send(32'd1000, 1'b0);
      idle(2);
      check_val("full_sum", last_sum[0], 64'd16000);
      check_val("full_cnt", 64'(last_cnt[0]), 64'd16);
      check_val("full_ovf", 64'(last_ovf[0]), 64'd0);

      // Early termination, then a fresh frame with no carry-over
      send(32'd10, 1'b0); send(32'd20, 1'b0); send(32'd30, 1'b1);
      idle(2);
      check_val("early_sum", last_sum[0], 64'd60);
      check_val("early_cnt", 64'(last_cnt[0]), 64'd3);
      for (int k = 0; k < LEN; k++) send(32'd1, 1'b0);
      idle(2);
      check_val("after_early_sum", last_sum[0], 64'd16);

      // Saturation on the 32-bit instance
      send(32'hC000_0000, 1'b0); send(32'hC000_0000, 1'b0);
      send(32'h10, 1'b0); send(32'h0, 1'b1);
      idle(2);
      check_val("sat_sum", last_sum[1], 64'hFFFF_FFFF);
      check_val("sat_ovf", 64'(last_ovf[1]), 64'd1);
      check_val("sat_cnt", 64'(last_cnt[1]), 64'd4);
      check_val("wide_sum", last_sum[0], 64'h1_8000_0010);
      check_val("wide_ovf", 64'(last_ovf[0]), 64'd0);
      send(32'd5, 1'b1);
      idle(2);
      check_val("post_sat_sum", last_sum[1], 64'd5);
      check_val("post_sat_ovf", 64'(last_ovf[1]), 64'd0);
      check_val("single_cnt", 64'(last_cnt[1]), 64'd1);

      // Backpressure: result held, offered beats ignored
      out_rdy = 1'b0;
      send(32'd100, 1'b0); send(32'd200, 1'b1);
      in_vld = 1'b1; in_prod = 32'd999; in_last = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_val("stall_rdy", 64'(in_rdy0), 64'd0);
         check_val("stall_sum", 64'(out_sum0), 64'd300);
         check_val("stall_cnt", 64'(out_cnt0), 64'd2);
         @(posedge clk); #1;
      end
      in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
      idle(2);
      check_val("bp_sum1", last_sum[0], 64'd300);
      send(32'd400, 1'b0); send(32'd500, 1'b1);
      idle(2);
      check_val("bp_sum2", last_sum[0], 64'd900);

      // Reset mid-frame discards the partial frame
      f0 = n_frames[0];
      for (int k = 0; k < 7; k++) send(32'd3, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      check_val("midrst_frames", 64'(n_frames[0]), 64'(f0));
      for (int k = 0; k < LEN; k++) send(32'd2, 1'b0);
      idle(2);
      check_val("midrst_sum", last_sum[0], 64'd32);
      check_val("midrst_frames2", 64'(n_frames[0]), 64'(f0 + 1));

      // Random soak
      fork
         begin
            for (int k = 0; k < 255; k++) begin
               idle($urandom_range(0, 2));
               r = $urandom_range(0, 32767);
               send(r * r, $urandom_range(0, 7) == 0);
            end
            soak_done = 1;
         end
         begin
            while (!soak_done) begin
               @(posedge clk); #1;
               out_rdy = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_rdy = 1'b1;
      idle(4);
      check_val("drain_q0", 64'(q0.size()), 64'd0);
      check_val("drain_q1", 64'(q1.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream stage of the 16x16 multiplier. Consumes its 32-bit unsigned products as a valid/ready stream.
- Accumulates the products into frames of up to LEN beats and emits one saturated sum per frame, with a beat count and an overflow flag.
- Serves as the accumulate half of the multiply-accumulate (dot-product) path.

Parameters:
- LEN, 16, maximum products per frame; must be at least 1.
- ACC_W, 40, accumulator and output sum width; must be at least 32.
- CNT_W, $clog2(LEN+1), width of the beat count.

Ports:
- sclk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_vld  input  1  in_prod is valid.
- in_rdy  output  1  the block can accept a beat.
- in_prod  input  32  unsigned product from the multiplier.
- in_last  input  1  this beat ends the frame early; qualified by acceptance.
- out_vld  output  1  the result registers hold an unconsumed frame result.
- out_rdy  input  1  the consumer takes the result.
- out_sum  output  ACC_W  saturated frame sum.
- out_cnt  output  CNT_W  number of beats in the frame (1..LEN).
- out_ovf  output  1  the frame sum saturated.

Behaviour:
- Interface: one clock, sclk. Reset is synchronous and active-high, on port rst.
- Reset: on rst=1 at a rising edge, acc, cnt, ovf_acc, out_vld, out_sum, out_cnt and out_ovf all go to 0. Reset overrides every other event in that cycle. A partial frame interrupted by reset is discarded and no result is emitted.
- Handshakes:
  - A beat is accepted when in_vld && in_rdy.
  - A result is consumed when out_vld && out_rdy.
- in_rdy = !out_vld || out_rdy. This is combinational from registered out_vld and the out_rdy input.
- Accept path, with internal acc (ACC_W bits), cnt (CNT_W bits) and ovf_acc:
  - base = (cnt==0) ? 0 : acc.
  - sum = base + zero-extended in_prod, computed at ACC_W+1 bits.
  - If the carry bit is set: sum is clamped to 2^ACC_W-1 and the overflow flag for this beat is 1.
  - After saturation, acc stays at max for every later beat of the frame.
- End of frame: the accepted beat has in_last=1, or cnt==LEN-1.
- On a frame-end beat, in the same edge:
  - out_sum <= sum.
  - out_cnt <= cnt+1.
  - out_ovf <= ovf_acc | this beat's overflow.
  - out_vld <= 1.
  - cnt <= 0 and ovf_acc <= 0.
- On any other accepted beat: acc <= sum, cnt <= cnt+1, ovf_acc accumulates.
- Latency: out_vld rises in the cycle after the final beat is accepted, and out_sum includes that beat.
- out_vld:
  - Clears on consumption, unless a frame ends in the same cycle; then it stays 1 and the new result loads.
  - out_sum, out_cnt and out_ovf hold stable while out_vld=1 and out_rdy=0.
- Throughput: with out_rdy held at 1, one beat is accepted per cycle and back-to-back frames run with no bubble.
- Stall: while out_vld=1 and out_rdy=0, in_rdy=0, no beats are accepted, and acc and cnt hold.
- Edge cases:
  - LEN=1: every beat is a frame.
  - in_last on the first beat of a frame gives out_cnt=1.
  - in_vld=0 cycles inside a frame are ignored and the frame stays open indefinitely.
  - in_last on a beat that is not accepted has no effect.
- State: an implicit two-state machine, ACCUM (out_vld=0) and PENDING (out_vld=1), with transitions as above. No other states.

Decomposition:
- Package accum_pkg holds:
  - the default constants LEN_DEF=16 and ACC_W_DEF=40;
  - PROD_W=32;
  - a localparam function for CNT_W.
- One natural sub-module, sat_add. It is a combinational unsigned ACC_W adder with a 32-bit addend, giving a saturated result and an overflow flag.
- Everything else is inline.

Test Plan:
- Full frame: with out_rdy=1, 16 beats of in_prod=1000 -> one out_vld pulse with out_sum=16000, out_cnt=16, out_ovf=0, and in_rdy=1 throughout.
- Early termination: beats 10, 20, 30 with in_last on 30 -> out_sum=60, out_cnt=3. A following 16-beat frame of value 1 -> out_sum=16, with no carry-over from the previous frame.
- Saturation: with ACC_W=32, beats 0xC0000000, 0xC0000000, 0x10, then in_last -> out_sum=0xFFFFFFFF and out_ovf=1. The next frame of value 5 with in_last -> out_sum=5 and out_ovf=0.
- Backpressure:
  - Complete a frame with out_rdy=0 for 5 cycles -> out_vld=1, outputs stable, in_rdy=0, and in_vld beats are ignored.
  - Then raise out_rdy -> consumed in 1 cycle and acceptance resumes.
  - The total over 2 frames matches the reference model.
- Reset mid-frame: after 7 accepted beats, rst for 1 cycle -> all outputs 0 and no result emitted. Then a 16-beat frame of value 2 -> out_sum=32.
- Random soak: 255 beats of random (0..32767)^2 with random in_vld, out_rdy and in_last -> every result matches the scoreboard sum, count and ovf.
